// File: rtl/imm_pkg.sv
// Shared types and field positions for the LEGv8 immediate generator.
// The S1 payload carries a 26-bit field already extended within its own width.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_I  = 3'd0,
    FMT_D  = 3'd1,
    FMT_B  = 3'd2,
    FMT_CB = 3'd3,
    FMT_IW = 3'd4
  } imm_fmt_t;

  localparam int FIELD_W = 26;
  localparam int SHAMT_W = 6;

  localparam int I_MSB  = 21;
  localparam int I_LSB  = 10;
  localparam int D_MSB  = 20;
  localparam int D_LSB  = 12;
  localparam int B_MSB  = 25;
  localparam int B_LSB  = 0;
  localparam int CB_MSB = 23;
  localparam int CB_LSB = 5;
  localparam int IW_MSB = 20;
  localparam int IW_LSB = 5;
  localparam int HW_MSB = 22;
  localparam int HW_LSB = 21;

  localparam int I_W  = I_MSB - I_LSB + 1;
  localparam int D_W  = D_MSB - D_LSB + 1;
  localparam int CB_W = CB_MSB - CB_LSB + 1;
  localparam int IW_W = IW_MSB - IW_LSB + 1;

  typedef struct packed {
    logic [FIELD_W-1:0] field;
    logic               sext;
    logic [SHAMT_W-1:0] shamt;
    logic               illegal;
  } imm_s1_t;

endpackage

// File: rtl/imm_field_extract.sv
// Combinational field extraction: picks the immediate bits for the selected
// format and resolves the final shift amount ahead of the S1 register.
module imm_field_extract
  import imm_pkg::*;
#(
  parameter bit SHIFT_BR = 1'b1
) (
  input  logic [31:0] instr,
  input  logic [2:0]  fmt,
  output imm_s1_t     payload
);

  localparam logic [SHAMT_W-1:0] BR_SHAMT = SHIFT_BR ? 6'd2 : 6'd0;

  logic unused_hi;
  assign unused_hi = ^instr[31:26];

  // Narrow signed fields are pre-extended to 26 bits so S2 only looks at bit 25.
  always_comb begin
    payload = '0;
    case (fmt)
      FMT_I: begin
        payload.field = {{(FIELD_W-I_W){1'b0}}, instr[I_MSB:I_LSB]};
      end
      FMT_D: begin
        payload.field = {{(FIELD_W-D_W){instr[D_MSB]}}, instr[D_MSB:D_LSB]};
        payload.sext  = 1'b1;
      end
      FMT_B: begin
        payload.field = instr[B_MSB:B_LSB];
        payload.sext  = 1'b1;
        payload.shamt = BR_SHAMT;
      end
      FMT_CB: begin
        payload.field = {{(FIELD_W-CB_W){instr[CB_MSB]}}, instr[CB_MSB:CB_LSB]};
        payload.sext  = 1'b1;
        payload.shamt = BR_SHAMT;
      end
      FMT_IW: begin
        payload.field = {{(FIELD_W-IW_W){1'b0}}, instr[IW_MSB:IW_LSB]};
        payload.shamt = {instr[HW_MSB:HW_LSB], 4'b0000};
      end
      default: begin
        payload.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Two-stage immediate generator: S1 registers the extracted field, S2 extends
// and shifts to OUT_W and drives the registered outputs.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int OUT_W    = 64,
  parameter bit SHIFT_BR = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [31:0]      instr,
  input  logic [2:0]       fmt,
  input  logic             stall,
  input  logic             flush,
  output logic [OUT_W-1:0] imm,
  output logic             imm_valid,
  output logic             fmt_err
);

  imm_s1_t          s1_next;
  imm_s1_t          s1_q;
  logic             s1_v;
  logic             s2_v;
  logic [OUT_W-1:0] ext;
  logic [OUT_W-1:0] imm_next;

  imm_field_extract #(.SHIFT_BR(SHIFT_BR)) u_extract (
    .instr  (instr),
    .fmt    (fmt),
    .payload(s1_next)
  );

  // Shifting in OUT_W bits drops anything pushed past the MSB, e.g. IW hw=2/3 at 32 bits.
  always_comb begin
    ext      = {{(OUT_W-FIELD_W){s1_q.sext & s1_q.field[FIELD_W-1]}}, s1_q.field};
    imm_next = s1_q.illegal ? '0 : (ext << s1_q.shamt);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_v    <= 1'b0;
      s2_v    <= 1'b0;
      imm     <= '0;
      fmt_err <= 1'b0;
    end else if (flush) begin
      s1_v    <= 1'b0;
      s2_v    <= 1'b0;
      fmt_err <= 1'b0;
    end else if (!stall) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_q <= s1_next;
      end
      s2_v <= s1_v;
      // imm keeps its last value across bubbles; fmt_err must not outlive its result.
      if (s1_v) begin
        imm     <= imm_next;
        fmt_err <= s1_q.illegal;
      end else begin
        fmt_err <= 1'b0;
      end
    end
  end

  assign imm_valid = s2_v;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench: two DUTs (64-bit scaled, 32-bit unscaled) share stimulus;
// expected results come from an arithmetic model of the format rules.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        reset, in_valid, stall, flush;
  logic [31:0] instr;
  logic [2:0]  fmt;
  logic [63:0] imm64;
  logic [31:0] imm32;
  logic        v64, v32, e64, e32;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] imm;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic        started = 1'b0;
  logic        last_rst = 1'b1;
  logic        last_stall = 1'b0;
  logic [63:0] prev_imm[2];
  logic        prev_v[2];
  logic        prev_e[2];

  always #5 clk = ~clk;

  imm_extend_pipe #(.OUT_W(64), .SHIFT_BR(1'b1)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .instr(instr), .fmt(fmt),
    .stall(stall), .flush(flush), .imm(imm64), .imm_valid(v64), .fmt_err(e64)
  );

  imm_extend_pipe #(.OUT_W(32), .SHIFT_BR(1'b0)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .instr(instr), .fmt(fmt),
    .stall(stall), .flush(flush), .imm(imm32), .imm_valid(v32), .fmt_err(e32)
  );

  // Value-level reference: field as a signed/unsigned integer, scaled by 2**shift, truncated.
  function automatic exp_t model(logic [31:0] in, logic [2:0] f, int ow, bit sb);
    exp_t        r;
    longint      v;
    int          sh;
    logic [63:0] u;
    r.err = 1'b0;
    v     = 0;
    sh    = 0;
    case (f)
      3'd0: v = longint'(in[21:10]);
      3'd1: v = longint'(in[20:12]) - (in[20] ? 512 : 0);
      3'd2: begin v = longint'(in[25:0]) - (in[25] ? 64'sd67108864 : 0); sh = sb ? 2 : 0; end
      3'd3: begin v = longint'(in[23:5]) - (in[23] ? 524288 : 0); sh = sb ? 2 : 0; end
      3'd4: begin v = longint'(in[20:5]); sh = 16 * int'(in[22:21]); end
      default: r.err = 1'b1;
    endcase
    u = 64'(v) * (64'd1 << sh);
    if (ow == 32) u = u & 64'h0000_0000_FFFF_FFFF;
    r.imm = u;
    return r;
  endfunction

  function automatic logic [31:0] put(logic [31:0] base, int msb, int lsb, logic [31:0] val);
    logic [31:0] w;
    w = base;
    for (int i = lsb; i <= msb; i++) w[i] = val[i-lsb];
    return w;
  endfunction

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Issue side: every instruction the pipeline accepts is queued; flush/reset kill what is in flight.
  always @(posedge clk) begin
    started    <= 1'b1;
    last_rst   <= !reset;
    last_stall <= reset && stall && !flush;
    if (!reset || flush) begin
      q0.delete();
      q1.delete();
    end else if (!stall && in_valid) begin
      q0.push_back(model(instr, fmt, 64, 1'b1));
      q1.push_back(model(instr, fmt, 32, 1'b0));
    end
  end

  task automatic mon(int k, logic v, logic [63:0] im, logic e);
    exp_t x;
    if (last_rst) begin
      chk("rst_valid", 64'(v), 64'd0);
      chk("rst_imm", im, 64'd0);
      chk("rst_err", 64'(e), 64'd0);
    end else if (last_stall) begin
      chk("stall_valid", 64'(v), 64'(prev_v[k]));
      chk("stall_imm", im, prev_imm[k]);
      chk("stall_err", 64'(e), 64'(prev_e[k]));
    end else if (v) begin
      if ((k == 0 ? q0.size() : q1.size()) == 0) begin
        chk("spurious_valid", 64'(v), 64'd0);
      end else begin
        x = (k == 0) ? q0.pop_front() : q1.pop_front();
        chk(k == 0 ? "imm64" : "imm32", im, x.imm);
        chk(k == 0 ? "err64" : "err32", 64'(e), 64'(x.err));
      end
    end else begin
      chk("err_when_idle", 64'(e), 64'd0);
    end
    prev_v[k]   = v;
    prev_imm[k] = im;
    prev_e[k]   = e;
  endtask

  always @(negedge clk) begin
    if (started) begin
      mon(0, v64, imm64, e64);
      mon(1, v32, {32'd0, imm32}, e32);
    end
  end

  task automatic drive(logic v, logic [31:0] ins, logic [2:0] f, logic st, logic fl, logic rs);
    in_valid = v;
    instr    = ins;
    fmt      = f;
    stall    = st;
    flush    = fl;
    reset    = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, $urandom, 3'd0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [31:0] w;
    int          n;
    in_valid = 1'b0; instr = '0; fmt = '0; stall = 1'b0; flush = 1'b0; reset = 1'b0;
    prev_imm = '{64'd0, 64'd0};
    prev_v   = '{1'b0, 1'b0};
    prev_e   = '{1'b0, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    idle(1);

    // Directed corner values, back-to-back.
    drive(1'b1, put($urandom, 21, 10, 32'hFFF), 3'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, put($urandom, 20, 12, 32'h100), 3'd1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, put($urandom, 23, 5, 32'h7FFFF), 3'd3, 1'b0, 1'b0, 1'b1);
    w = put($urandom, 20, 5, 32'hBEEF);
    drive(1'b1, put(w, 22, 21, 32'd3), 3'd4, 1'b0, 1'b0, 1'b1);
    drive(1'b1, put($urandom, 25, 0, 32'h2000000), 3'd2, 1'b0, 1'b0, 1'b1);
    drive(1'b1, $urandom, 3'd6, 1'b0, 1'b0, 1'b1);
    idle(3);

    // Stream with a two-cycle stall; inputs offered during the stall are dropped.
    drive(1'b1, $urandom, 3'd1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, $urandom, 3'd3, 1'b0, 1'b0, 1'b1);
    drive(1'b1, $urandom, 3'd0, 1'b1, 1'b0, 1'b1);
    drive(1'b1, $urandom, 3'd2, 1'b1, 1'b0, 1'b1);
    drive(1'b1, $urandom, 3'd4, 1'b0, 1'b0, 1'b1);
    idle(3);

    // Flush with both stages full, then flush together with stall.
    drive(1'b1, $urandom, 3'd1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, $urandom, 3'd7, 1'b0, 1'b0, 1'b1);
    drive(1'b1, $urandom, 3'd0, 1'b0, 1'b1, 1'b1);
    idle(2);
    drive(1'b1, $urandom, 3'd5, 1'b0, 1'b0, 1'b1);
    drive(1'b1, $urandom, 3'd3, 1'b0, 1'b0, 1'b1);
    drive(1'b1, $urandom, 3'd2, 1'b1, 1'b1, 1'b1);
    idle(2);

    // Reset with s1 occupied by an illegal-format result.
    drive(1'b1, $urandom, 3'd6, 1'b0, 1'b0, 1'b1);
    drive(1'b1, $urandom, 3'd4, 1'b1, 1'b1, 1'b0);
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      n = $urandom_range(0, 99);
      drive($urandom_range(0, 9) < 8, $urandom, 3'($urandom_range(0, 7)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, n != 0);
    end

    idle(1);
    for (int i = 0; i < 10 && (q0.size() != 0 || q1.size() != 0); i++) idle(1);
    chk("drain_q64", 64'(q0.size()), 64'd0);
    chk("drain_q32", 64'(q1.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
